// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Pulls the shared open-drain lines low through output enables only; never drives high.
module ps2_host_tx #(
  parameter int counterBits   = 12,
  parameter int inhibitCycles = 1000,
  parameter int timeoutCycles = 4000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  input  logic [7:0] txData,
  input  logic       txStart,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    WAIT_IDLE,
    FINISH
  } state_t;

  localparam logic [counterBits-1:0] inhibitLast = counterBits'(inhibitCycles - 1);
  localparam logic [counterBits-1:0] timeoutLast = counterBits'(timeoutCycles - 1);

  state_t                 state;
  logic [1:0]             clkSync;
  logic [1:0]             dataSync;
  logic                   clkPrev;
  logic [8:0]             shift;
  logic [3:0]             bitCount;
  logic [counterBits-1:0] count;
  logic                   fallEdge;
  logic                   timedOut;
  logic                   watched;

  assign fallEdge = clkPrev & ~clkSync[1];
  assign timedOut = (count == timeoutLast);
  assign watched  = state inside {REQUEST, SHIFT, ACK, WAIT_IDLE};

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      clkPrev  <= 1'b1;
    end else begin
      clkSync  <= {clkSync[0], ps2ClkIn};
      dataSync <= {dataSync[0], ps2DataIn};
      clkPrev  <= clkSync[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ps2ClkOe  <= 1'b0;
      ps2DataOe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      shift     <= '0;
      bitCount  <= '0;
      count     <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      count <= count + counterBits'(1);
      if (watched && fallEdge) count <= '0;

      case (state)
        IDLE, FINISH: begin
          state     <= IDLE;
          count     <= '0;
          ps2ClkOe  <= 1'b0;
          ps2DataOe <= 1'b0;
          busy      <= 1'b0;
          if (txStart) begin
            shift    <= {~^txData, txData};
            busy     <= 1'b1;
            ps2ClkOe <= 1'b1;
            state    <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (count == inhibitLast) begin
            ps2DataOe <= 1'b1;
            count     <= '0;
            state     <= REQUEST;
          end
        end

        // The first device edge already clocks out data bit 0.
        REQUEST: begin
          ps2ClkOe <= 1'b0;
          if (fallEdge) begin
            ps2DataOe <= ~shift[0];
            shift     <= {1'b1, shift[8:1]};
            bitCount  <= '0;
            state     <= SHIFT;
          end
        end

        // Ones shifted in from the top become the stop bit on the last edge.
        SHIFT: begin
          if (fallEdge) begin
            ps2DataOe <= ~shift[0];
            shift     <= {1'b1, shift[8:1]};
            bitCount  <= bitCount + 4'd1;
            if (bitCount == 4'd8) state <= ACK;
          end
        end

        ACK: begin
          if (fallEdge) begin
            if (dataSync[1]) begin
              ps2ClkOe  <= 1'b0;
              ps2DataOe <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              error     <= 1'b1;
              state     <= FINISH;
            end else begin
              state <= WAIT_IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (clkSync[1] && dataSync[1]) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FINISH;
          end
        end

        default: state <= IDLE;
      endcase

      if (watched && timedOut && !fallEdge) begin
        ps2ClkOe  <= 1'b0;
        ps2DataOe <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
        error     <= 1'b1;
        state     <= FINISH;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx
// Open-drain bus model with a clocking keyboard device and a done-driven scoreboard.
module tb_ps2_host_tx;

  localparam int INHIBIT = 1000;
  localparam int TIMEOUT = 4000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       txStart = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       ps2ClkIn;
  logic       ps2DataIn;
  logic       ps2ClkOe;
  logic       ps2DataOe;
  logic       busy;
  logic       done;
  logic       error;

  assign ps2ClkIn  = ~(ps2ClkOe | devClkLow);
  assign ps2DataIn = ~(ps2DataOe | devDataLow);

  ps2_host_tx #(
    .counterBits  (12),
    .inhibitCycles(INHIBIT),
    .timeoutCycles(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2ClkIn (ps2ClkIn),
    .ps2DataIn(ps2DataIn),
    .ps2ClkOe (ps2ClkOe),
    .ps2DataOe(ps2DataOe),
    .txData   (txData),
    .txStart  (txStart),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       ackLow;
    logic [9:0] expBits;
    logic       expErr;
  } vec_t;

  typedef struct {
    logic       expErr;
    logic       checkBits;
    logic [9:0] expBits;
  } sb_t;

  sb_t        sbq[$];
  logic [9:0] obsq[$];
  vec_t       vecs[5];
  int         nCmp = 0;
  int         nBad = 0;
  int         cyc = 0;
  int         clkRise = -1;
  int         dataRise = -1;
  int         doneCyc = -1;
  logic       prevClkOe = 1'b0;
  logic       prevDataOe = 1'b0;
  logic       prevDone = 1'b0;
  sb_t        cur;
  logic [9:0] got;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    nCmp++;
    if (actual !== want) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", name, actual, want);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ps2ClkOe && !prevClkOe) clkRise = cyc;
    if (ps2DataOe && !prevDataOe && ps2ClkOe) dataRise = cyc;
    if (prevDone) check("done_width", done, 0);
    if (done) begin
      doneCyc = cyc;
      check("busy_at_done", busy, 0);
      check("lines_at_done", {ps2ClkOe, ps2DataOe}, 0);
      if (sbq.size() == 0) begin
        nCmp++;
        nBad++;
        $display("FAIL unexpected_done: got done=1 want no transfer pending");
      end else begin
        cur = sbq.pop_front();
        check("error_at_done", error, cur.expErr);
        if (cur.checkBits) begin
          if (obsq.size() == 0) begin
            nCmp++;
            nBad++;
            $display("FAIL frame_bits: got no frame want %b", cur.expBits);
          end else begin
            got = obsq.pop_front();
            check("frame_bits", got, cur.expBits);
          end
        end
      end
    end else begin
      check("error_without_done", error, 0);
    end
    prevClkOe  = ps2ClkOe;
    prevDataOe = ps2DataOe;
    prevDone   = done;
  end

  task automatic device(input logic ackLow, input logic inject);
    logic [9:0] bits;
    int         n;
    bits = '0;
    n = 0;
    if (inject) txData = 8'h3C;
    while (!(ps2DataOe && !ps2ClkOe) && n < INHIBIT + 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= INHIBIT + 100) begin
      nCmp++;
      nBad++;
      $display("FAIL request_wait: got no request want request within %0d cycles", INHIBIT + 100);
      return;
    end
    repeat (50) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      devClkLow = 1'b1;
      if (k == 11) devDataLow = ackLow;
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        txStart = inject && (k == 4) && (j == 10);
      end
      devClkLow = 1'b0;
      for (int j = 0; j < 100; j++) begin
        @(negedge clk);
        if (j == 50 && k <= 10) bits[k-1] = ps2DataIn;
        if (j == 10 && k == 11) devDataLow = 1'b0;
      end
      if (k == 10) obsq.push_back(bits);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      nCmp++;
      nBad++;
      $display("FAIL done_wait: got no done want done within %0d cycles", budget);
      sbq.delete();
    end
  endtask

  task automatic run_frame(input vec_t v, input logic inject);
    sb_t s;
    @(negedge clk);
    check("busy_before_start", busy, 0);
    txData  = v.data;
    txStart = 1'b1;
    s = '{v.expErr, 1'b1, v.expBits};
    sbq.push_back(s);
    @(negedge clk);
    txStart = 1'b0;
    check("busy_after_start", busy, 1);
    check("clkoe_after_start", ps2ClkOe, 1);
    device(v.ackLow, inject);
    wait_done(200);
    check("inhibit_length", dataRise - clkRise, INHIBIT);
  endtask

  initial begin
    logic sawClkOe;
    sb_t  s;

    vecs[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED}, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF}, 1'b0};
    vecs[2] = '{8'h00, 1'b1, {1'b1, 1'b1, 8'h00}, 1'b0};
    vecs[3] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01}, 1'b0};
    vecs[4] = '{8'h55, 1'b0, {1'b1, 1'b1, 8'h55}, 1'b1};

    @(negedge clk);
    check("reset_clkoe", ps2ClkOe, 0);
    check("reset_dataoe", ps2DataOe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 1'b0);
      repeat (20) @(negedge clk);
    end

    run_frame('{8'hA3, 1'b1, {1'b1, 1'b1, 8'hA3}, 1'b0}, 1'b1);
    sawClkOe = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ps2ClkOe || busy) sawClkOe = 1'b1;
    end
    check("no_restart_after_ignored_start", sawClkOe, 0);

    @(negedge clk);
    txData  = 8'h12;
    txStart = 1'b1;
    s = '{1'b1, 1'b0, 10'd0};
    sbq.push_back(s);
    @(negedge clk);
    txStart = 1'b0;
    wait_done(INHIBIT + TIMEOUT + 100);
    check("timeout_latency", doneCyc - dataRise, TIMEOUT);
    repeat (20) @(negedge clk);

    txData  = 8'h77;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_inhibit_clkoe", ps2ClkOe, 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_clkoe", ps2ClkOe, 0);
    check("async_reset_dataoe", ps2DataOe, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_done", done, 0);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
